pipelined_rca: RTL and testbench
================================

Name: pipelined_rca

Overview:
Parametrised, pipelined ripple-carry adder/subtractor with valid/ready handshakes on input and output. Operands are split into STAGES equal slices. Each pipeline stage ripples one slice and registers its carry into the next stage. This is the successor to the 4-bit combinational ripple_carry_adder (a, b, c, sum, carry). It is used where wide operands must close timing at one result per clock.

Parameters:
WIDTH, 16, operand and result width in bits; must be a multiple of STAGES
STAGES, 4, number of pipeline stages (1..WIDTH); slice width SLICE = WIDTH/STAGES

Ports:
clk  input  1  rising-edge clock; the block's only clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  a/b/c/sub hold a valid operation
in_ready  output  1  block can accept this cycle; transfer when in_valid && in_ready
a  input  WIDTH  operand A, unsigned or two's complement
b  input  WIDTH  operand B
c  input  1  carry-in (add mode) / borrow-in (sub mode)
sub  input  1  0: add, 1: subtract
out_valid  output  1  sum/carry/ovf hold a result
out_ready  input  1  consumer accepts; transfer when out_valid && out_ready
sum  output  WIDTH  result
carry  output  1  raw carry out of MSB (sub mode: 1 = no borrow)
ovf  output  1  two's-complement overflow (carry into MSB xor carry out of MSB)

Behaviour:
- Arithmetic:
  - add: {carry,sum} = a + b + c.
  - sub: {carry,sum} = a + ~b + ~c, i.e. sum = a - b - c mod 2^WIDTH.
  - Inversion of b and c is applied at capture.
  - All arithmetic is modulo 2^WIDTH, with no saturation.
- Pipeline structure:
  - Stage k (0..STAGES-1) adds slice k, bits [k*SLICE +: SLICE].
  - It uses the carry registered by stage k-1; stage 0 uses the captured carry-in.
  - Result slices already computed travel forward alongside the unprocessed operand slices (skew registers).
  - Each stage has a valid bit.
- Latency: exactly STAGES cycles from the accepting edge to out_valid=1, with no stalls. Throughput is one op per cycle.
- Flow control:
  - Stage k advances when its successor is empty or advancing.
  - The last stage advances when out_ready=1.
  - in_ready = !valid[0] || stage 0 advancing. in_ready is combinational from pipeline state and out_ready; it never depends on in_valid.
  - When stalled, bubbles collapse: an empty stage accepts even if the stage ahead of it is blocked.
- Outputs are driven directly from the last stage's registers and are stable while out_valid && !out_ready.
- Ordering: results leave in acceptance order. No drop, no duplication.
- Occupancy: at most STAGES operations in flight. When all stages are full and out_ready=0, in_ready=0.
- Simultaneous out-transfer and in-transfer with all stages full: both occur in the same cycle and occupancy is unchanged.
- Reset (rst=1 at clk edge):
  - All valid bits clear: out_valid=0, in_ready=1 on the next cycle.
  - sum=0, carry=0, ovf=0; all data and carry registers are 0.
  - Reset mid-operation discards in-flight ops; none is ever emitted.
- STAGES=1: degenerates to a single registered adder with latency 1.
- STAGES=WIDTH: one bit per stage.
- Inputs are don't-care when in_valid=0. X on a/b must not propagate into valid bits.

Decomposition:
- Package rca_pkg holds:
  - a function computing SLICE;
  - a compile-time check that WIDTH % STAGES == 0;
  - a typedef for the per-stage record {valid, carry, ovf_in, partial_sum, a_rem, b_rem}.
- One sub-module, rca_slice: combinational SLICE-bit ripple adder (inputs x, y, cin; outputs s, cout, and carry into its MSB for ovf). It is instantiated once per stage via generate.

Test Plan (WIDTH=16, STAGES=4 unless stated):
1. Hold rst=1 for 2 cycles, then release -> out_valid=0, sum=0x0000, carry=0, ovf=0, in_ready=1. No output appears for 10 idle cycles.
2. Add a=0x0003, b=0x0005, c=0, with out_ready=1 -> exactly 4 cycles later sum=0x0008, carry=0, ovf=0 for one cycle.
3. Full-ripple cases:
   - a=0xFFFF, b=0x0001, c=0 -> sum=0x0000, carry=1, ovf=0.
   - a=0xFFFF, b=0xFFFF, c=1 -> sum=0xFFFF, carry=1.
4. Subtract:
   - a=0x0005, b=0x0007, c=0, sub=1 -> sum=0xFFFE, carry=0, ovf=0.
   - a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, carry=1, ovf=1.
   - a=0x7FFF, b=0x0001, add -> sum=0x8000, ovf=1.
5. Backpressure:
   - Stream 8 back-to-back ops (a=i, b=i).
   - Drop out_ready for 5 cycles once the first result is valid.
   - Required: in_ready=0 when 4 ops are held; outputs stay stable; all 8 results 2*i arrive in order with no loss.
   - Also run with STAGES=1 and STAGES=16.
6. Assert rst for 1 cycle while 3 ops are in flight -> out_valid=0 the next cycle. None of the 3 results ever appears. A new op issued after reset returns correctly in 4 cycles.

Source files
------------

// File: rtl/rca_pkg.sv
// Shared definitions for the pipelined ripple-carry adder/subtractor.
//   slice_width() : bits handled by one pipeline stage
//   geometry_ok() : legality of a WIDTH/STAGES pair, checked at elaboration
//   stage_ctl_t   : control part of a stage record (valid, carry, overflow)
// The full stage record also holds WIDTH-dependent data vectors, so it is declared
// in the top module.
package rca_pkg;

    function automatic int unsigned slice_width(input int unsigned width,
                                                input int unsigned stages);
        return width / stages;
    endfunction

    function automatic bit geometry_ok(input int unsigned width, input int unsigned stages);
        return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
    endfunction

    typedef struct packed {
        logic valid;
        logic carry;   // carry out of this stage's slice
        logic ovf;     // overflow flag; meaningful only in the last stage
    } stage_ctl_t;

endpackage

// File: rtl/rca_slice.sv
// Combinational SLICE-bit ripple adder.
//   x, y    : slice operands
//   cin     : carry into bit 0
//   s       : slice sum
//   cout    : carry out of the slice MSB
//   cin_msb : carry into the slice MSB (overflow detection in the top slice)
module rca_slice #(
    parameter int unsigned SLICE = 4
) (
    input  logic [SLICE-1:0] x,
    input  logic [SLICE-1:0] y,
    input  logic             cin,
    output logic [SLICE-1:0] s,
    output logic             cout,
    output logic             cin_msb
);

    logic [SLICE:0] chain;

    always_comb begin
        chain    = '0;
        s        = '0;
        chain[0] = cin;
        for (int i = 0; i < int'(SLICE); i++) begin
            s[i]       = x[i] ^ y[i] ^ chain[i];
            chain[i+1] = (x[i] & y[i]) | (chain[i] & (x[i] ^ y[i]));
        end
    end

    assign cout    = chain[SLICE];
    assign cin_msb = chain[SLICE-1];

endmodule

// File: rtl/pipelined_rca.sv
// Pipelined ripple-carry adder/subtractor with valid/ready handshakes.
//   clk, rst                  : clock, synchronous active-high reset
//   in_valid/in_ready         : input handshake for a, b, c (carry/borrow in), sub
//   out_valid/out_ready       : output handshake for sum, carry, ovf
// Stage k adds bits [k*SLICE +: SLICE] using the carry registered by stage k-1.
// Finished sum slices and not-yet-used operand bits travel along with each op.
// One result per clock, latency STAGES cycles when not stalled.
module pipelined_rca
    import rca_pkg::*;
#(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             ovf
);

    localparam int unsigned SLICE = slice_width(WIDTH, STAGES);
    localparam int unsigned LAST  = STAGES - 1;

    if (!geometry_ok(WIDTH, STAGES)) begin : g_bad_geometry
        $error("pipelined_rca: STAGES must be 1..WIDTH and divide WIDTH");
    end

    typedef struct packed {
        stage_ctl_t       ctl;
        logic [WIDTH-1:0] partial_sum;
        logic [WIDTH-1:0] a_rem;
        logic [WIDTH-1:0] b_rem;   // already inverted in subtract mode
    } stage_t;

    stage_t            stage_q [STAGES];
    stage_t            stage_d [STAGES];
    logic [STAGES-1:0] load;
    logic [STAGES-1:0] adv;
    logic [STAGES:0]   room;   // room[k]: stage k can take a new op this cycle

    // Walk from the output backwards: a stage advances when the one ahead has room,
    // and a stage has room when it is empty or advancing (bubbles collapse).
    always_comb begin
        room         = '0;
        adv          = '0;
        room[STAGES] = out_ready;
        for (int k = int'(STAGES) - 1; k >= 0; k--) begin
            adv[k]  = stage_q[k].ctl.valid & room[k+1];
            room[k] = ~stage_q[k].ctl.valid | adv[k];
        end
    end

    assign in_ready = room[0];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [WIDTH-1:0] src_sum;
        logic [WIDTH-1:0] src_a;
        logic [WIDTH-1:0] src_b;
        logic             src_carry;
        logic [SLICE-1:0] s;
        logic             cout;
        logic             cin_msb;
        stage_t           nxt;

        if (k == 0) begin : g_first
            // Subtraction is a + ~b + ~c, so inversion happens at capture.
            assign src_sum   = '0;
            assign src_a     = a;
            assign src_b     = b ^ {WIDTH{sub}};
            assign src_carry = c ^ sub;
            assign load[k]   = in_valid & in_ready;
        end else begin : g_next
            assign src_sum   = stage_q[k-1].partial_sum;
            assign src_a     = stage_q[k-1].a_rem;
            assign src_b     = stage_q[k-1].b_rem;
            assign src_carry = stage_q[k-1].ctl.carry;
            assign load[k]   = adv[k-1];
        end

        rca_slice #(
            .SLICE(SLICE)
        ) u_slice (
            .x      (src_a[k*SLICE +: SLICE]),
            .y      (src_b[k*SLICE +: SLICE]),
            .cin    (src_carry),
            .s      (s),
            .cout   (cout),
            .cin_msb(cin_msb)
        );

        always_comb begin
            nxt                               = '0;
            nxt.ctl.valid                     = 1'b1;
            nxt.ctl.carry                     = cout;
            nxt.ctl.ovf                       = cin_msb ^ cout;
            nxt.partial_sum                   = src_sum;
            nxt.partial_sum[k*SLICE +: SLICE] = s;
            nxt.a_rem                         = src_a;
            nxt.b_rem                         = src_b;
        end

        assign stage_d[k] = nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < int'(STAGES); k++) begin
                stage_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < int'(STAGES); k++) begin
                if (load[k]) begin
                    stage_q[k] <= stage_d[k];
                end else if (adv[k]) begin
                    stage_q[k].ctl.valid <= 1'b0;
                end
            end
        end
    end

    assign out_valid = stage_q[LAST].ctl.valid;
    assign sum       = stage_q[LAST].partial_sum;
    assign carry     = stage_q[LAST].ctl.carry;
    assign ovf       = stage_q[LAST].ctl.ovf;

    // Operand leftovers in the last stage and intermediate overflow flags are never used.
    logic unused_bits;
    always_comb begin
        unused_bits = ^{stage_q[LAST].a_rem, stage_q[LAST].b_rem};
        for (int k = 0; k < int'(STAGES); k++) begin
            unused_bits = unused_bits ^ stage_q[k].ctl.ovf;
        end
    end

endmodule

// File: tb/tb_pipelined_rca.sv
// Bench for pipelined_rca: three instances (STAGES = 4, 1, 16, WIDTH = 16) share data
// inputs and out_ready; each has its own in_valid. A behavioural model computes each
// result with integer arithmetic and a per-instance queue tracks acceptance order.
module tb_pipelined_rca;

    localparam int W    = 16;
    localparam int NDUT = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic [W-1:0]    a;
    logic [W-1:0]    b;
    logic            c;
    logic            sub;
    logic            out_ready;
    logic [NDUT-1:0] in_valid;
    logic [NDUT-1:0] in_ready;
    logic [NDUT-1:0] out_valid;
    logic [NDUT-1:0] carry;
    logic [NDUT-1:0] ovf;
    logic [W-1:0]    sum [NDUT];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [W+1:0] expq [NDUT][$];   // {carry, ovf, sum}
    int           accq [NDUT][$];   // acceptance cycle of each queued op
    int           got  [NDUT];
    logic         held [NDUT];
    logic [W+1:0] held_val [NDUT];
    logic [W+1:0] last_val [NDUT];

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int unsigned S = (g == 0) ? 4 : ((g == 1) ? 1 : 16);
        pipelined_rca #(
            .WIDTH (W),
            .STAGES(S)
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .in_valid (in_valid[g]),
            .in_ready (in_ready[g]),
            .a        (a),
            .b        (b),
            .c        (c),
            .sub      (sub),
            .out_valid(out_valid[g]),
            .out_ready(out_ready),
            .sum      (sum[g]),
            .carry    (carry[g]),
            .ovf      (ovf[g])
        );
    end

    function automatic int stg(input int g);
        return (g == 0) ? 4 : ((g == 1) ? 1 : 16);
    endfunction

    // Result of a +/- b +/- c as plain integers, then reduced to the output fields.
    function automatic logic [W+1:0] model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                           input logic cv, input logic sv);
        int ua;
        int ub;
        int sa;
        int sb;
        int u;
        int s;
        logic [W-1:0] r;
        logic cr;
        logic ov;
        ua = int'(av);
        ub = int'(bv);
        sa = int'($signed(av));
        sb = int'($signed(bv));
        if (sv) begin
            u  = ua - ub - int'(cv);
            s  = sa - sb - int'(cv);
            cr = (u >= 0);
        end else begin
            u  = ua + ub + int'(cv);
            s  = sa + sb + int'(cv);
            cr = (u > 65535);
        end
        r  = u[W-1:0];
        ov = (s > 32767) || (s < -32768);
        return {cr, ov, r};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Scoreboard: runs every cycle, mid-cycle, after inputs and outputs have settled.
    always @(negedge clk) begin
        cyc++;
        for (int g = 0; g < NDUT; g++) begin
            if (rst) begin
                expq[g].delete();
                accq[g].delete();
                held[g] = 1'b0;
            end else begin
                check("in_ready_rule", in_ready[g],
                      (expq[g].size() < stg(g)) || out_ready);
                if (held[g]) begin
                    check("hold_valid", out_valid[g], 1);
                    check("hold_data", {carry[g], ovf[g], sum[g]}, held_val[g]);
                end
                if (out_valid[g]) begin
                    if (expq[g].size() == 0) begin
                        check("spurious_out", out_valid[g], 0);
                    end else begin
                        check("result", {carry[g], ovf[g], sum[g]}, expq[g][0]);
                        check("latency_min", (cyc - accq[g][0]) >= stg(g), 1);
                        if (out_ready) begin
                            last_val[g] = expq[g][0];
                            void'(expq[g].pop_front());
                            void'(accq[g].pop_front());
                            got[g]++;
                        end
                    end
                end
                held[g]     = out_valid[g] && !out_ready;
                held_val[g] = {carry[g], ovf[g], sum[g]};
                if (in_valid[g] && in_ready[g]) begin
                    expq[g].push_back(model(a, b, c, sub));
                    accq[g].push_back(cyc);
                end
            end
        end
    end

    // Presents one op to instance g and returns just after the edge that accepted it.
    task automatic issue(input int g, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic cv, input logic sv);
        int n = 0;
        a           = av;
        b           = bv;
        c           = cv;
        sub         = sv;
        in_valid[g] = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready[g] && n < 100);
        if (!in_ready[g]) check("issue_timeout", in_ready[g], 1);
        @(posedge clk);
        #1;
        in_valid[g] = 1'b0;
    endtask

    task automatic expect_op(input int g, input logic [W-1:0] av, input logic [W-1:0] bv,
                             input logic cv, input logic sv, input logic [W-1:0] es,
                             input logic ec, input logic eo, input string name);
        int n = 0;
        out_ready = 1'b1;
        issue(g, av, bv, cv, sv);
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid[g] && n < 50);
        check({name, "_latency"}, n, stg(g));
        check({name, "_sum"}, sum[g], es);
        check({name, "_carry"}, carry[g], ec);
        check({name, "_ovf"}, ovf[g], eo);
        @(negedge clk);
        check({name, "_one_cycle"}, out_valid[g], 0);
        @(posedge clk);
        #1;
    endtask

    task automatic stream_test(input int g);
        int base = got[g];
        int n    = 0;
        out_ready = 1'b1;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    logic [W-1:0] v;
                    v = i[W-1:0];
                    issue(g, v, v, 1'b0, 1'b0);
                end
            end
            begin
                int m = 0;
                do begin
                    @(negedge clk);
                    m++;
                end while (!out_valid[g] && m < 100);
                check("stream_first_out", out_valid[g], 1);
                @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (4) @(posedge clk);
                @(negedge clk);
                // 16 stages never fill with 8 ops; the shallower pipelines are full here.
                check("stall_in_ready", in_ready[g], (g == 2) ? 1 : 0);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        while (expq[g].size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("stream_drained", expq[g].size(), 0);
        check("stream_count", got[g] - base, 8);
        check("stream_last", last_val[g], {2'b00, 16'd14});
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst       = 1'b1;
        in_valid  = '0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        c         = 1'b0;
        sub       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state and idle behaviour.
        @(negedge clk);
        for (int g = 0; g < NDUT; g++) begin
            check("rst_out_valid", out_valid[g], 0);
            check("rst_sum", sum[g], 16'h0000);
            check("rst_carry", carry[g], 0);
            check("rst_ovf", ovf[g], 0);
            check("rst_in_ready", in_ready[g], 1);
        end
        n = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid[0]) n++;
        end
        check("idle_outputs", n, 0);
        @(posedge clk);
        #1;

        // Directed arithmetic with hand-computed results.
        expect_op(0, 16'h0003, 16'h0005, 1'b0, 1'b0, 16'h0008, 1'b0, 1'b0, "add_3_5");
        expect_op(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, "ripple_ffff_1");
        expect_op(0, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0, "ripple_ffff_ffff_c");
        expect_op(0, 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, "sub_5_7");
        expect_op(0, 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, "sub_8000_1");
        expect_op(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, "add_7fff_1");
        expect_op(0, 16'h0010, 16'h0003, 1'b1, 1'b1, 16'h000C, 1'b1, 1'b0, "sub_borrow_in");
        expect_op(1, 16'h0003, 16'h0005, 1'b0, 1'b0, 16'h0008, 1'b0, 1'b0, "s1_add");
        expect_op(1, 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, "s1_sub");
        expect_op(2, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, "s16_ripple");
        expect_op(2, 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, "s16_sub");

        // Back-to-back stream with a 5-cycle output stall, on every depth.
        for (int g = 0; g < NDUT; g++) begin
            stream_test(g);
        end

        // Reset with three ops in flight: none may ever come out.
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            logic [W-1:0] v;
            v = 16'd100 + i[W-1:0];
            issue(0, v, 16'h0001, 1'b0, 1'b0);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", out_valid[0], 0);
        check("midrst_in_ready", in_ready[0], 1);
        n = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid[0]) n++;
        end
        check("midrst_no_output", n, 0);
        @(posedge clk);
        #1;
        expect_op(0, 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0, "post_rst");

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
